pipe_arb_sched: RTL and testbench

- Shares one 3-stage arithmetic pipeline between NREQ requesters. The pipeline computes F = ((A+B)+(C-D))*D.
- Each requester offers an operand set {A,B,C,D} with a req/gnt handshake.
- A round-robin scheduler issues at most one operation per cycle and carries the requester ID alongside the data.
- Results leave through a valid/ready output port with backpressure.

---
 rtl/pipe_arb_pkg.sv | 23 ++
 rtl/pipe_arb_sched_rr_arbiter.sv | 56 +++++
 rtl/pipe_arb_sched.sv | 116 +++++++++++
 tb/tb_pipe_arb_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_arb_pkg.sv
// pipe_arb_pkg
// Shared defaults and types for the pipe_arb_sched slice.
//   DEF_N     : default operand/result width
//   DEF_NREQ  : default number of requesters
//   DEF_IDW   : default requester-ID width
//   PIPE_LAT  : issue-to-output latency of the arithmetic pipeline in cycles
//   stage_t   : one pipeline stage record {valid, sum, d, id}
// Optional feature macro used by this slice: PIPE_ARB_PRIO0_EN
package pipe_arb_pkg;

    localparam int DEF_N    = 9;
    localparam int DEF_NREQ = 4;
    localparam int DEF_IDW  = $clog2(DEF_NREQ);
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic               valid;
        logic [DEF_N-1:0]   sum;
        logic [DEF_N-1:0]   d;
        logic [DEF_IDW-1:0] id;
    } stage_t;

endpackage

// File: rtl/pipe_arb_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin grant search for pipe_arb_sched.
//   req    : request vector, one bit per requester
//   enable : when low no grant is issued (reset or pipeline stall)
//   ptr    : index of the last round-robin winner; search starts at ptr+1
//   gnt    : one-hot grant
//   idx    : binary index of the granted requester (0 when no grant)
// Macro PIPE_ARB_PRIO0_EN: requester 0 wins whenever it requests; the
// remaining requesters rotate among themselves.
module rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic found;
    int   cand;

    // Walk the requesters from ptr+1 around to ptr itself; the first set
    // request wins. In priority mode requester 0 is taken first and then
    // skipped by the rotation so the pointer only tracks requesters 1..NREQ-1.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        if (enable) begin
`ifdef PIPE_ARB_PRIO0_EN
            if (req[0]) begin
                gnt[0] = 1'b1;
                found  = 1'b1;
            end
`endif
            for (int k = 1; k <= NREQ; k++) begin
                cand = (int'(ptr) + k) % NREQ;
`ifdef PIPE_ARB_PRIO0_EN
                if (!found && cand != 0 && req[cand]) begin
`else
                if (!found && req[cand]) begin
`endif
                    gnt[cand] = 1'b1;
                    idx       = cand[IDW-1:0];
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_arb_sched.sv
// pipe_arb_sched
// Shares one 3-stage pipeline computing F = ((A+B)+(C-D))*D (mod 2^N)
// among NREQ requesters, with round-robin issue and a valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req                 : per-requester operand-valid
//   op_a/op_b/op_c/op_d : operands, requester i uses slice [i*N +: N]
//   gnt                 : combinational one-hot grant (transfer = req & gnt)
//   out_valid/out_ready : result handshake
//   out_f, out_id       : result and issuing requester index
//   busy                : any pipeline stage holds a valid operation
// Macro PIPE_ARB_PRIO0_EN: requester 0 has fixed priority over the rest.
module pipe_arb_sched
    import pipe_arb_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*N-1:0] op_a,
    input  logic [NREQ*N-1:0] op_b,
    input  logic [NREQ*N-1:0] op_c,
    input  logic [NREQ*N-1:0] op_d,
    output logic [NREQ-1:0] gnt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_f,
    output logic [IDW-1:0]  out_id,
    output logic            busy
);

    logic           stall;
    logic           grant_any;
    logic           ptr_load;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic [N-1:0]   sel_a, sel_b, sel_c, sel_d;

    logic           s1_valid;
    logic [N-1:0]   s1_sum;
    logic [N-1:0]   s1_dif;
    logic [N-1:0]   s1_d;
    logic [IDW-1:0] s1_id;
    stage_t         s2;

    // A held result freezes the whole pipe, so nothing may be issued either.
    assign stall     = out_valid && !out_ready;
    assign grant_any = |gnt;
    assign busy      = s1_valid | s2.valid | out_valid;

`ifdef PIPE_ARB_PRIO0_EN
    assign ptr_load = |gnt[NREQ-1:1];
`else
    assign ptr_load = grant_any;
`endif

    assign sel_a = op_a[gnt_idx*N +: N];
    assign sel_b = op_b[gnt_idx*N +: N];
    assign sel_c = op_c[gnt_idx*N +: N];
    assign sel_d = op_d[gnt_idx*N +: N];

    // Gating enable with rst_n keeps gnt low for the whole reset pulse.
    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req),
        .enable (rst_n && !stall),
        .ptr    (ptr),
        .gnt    (gnt),
        .idx    (gnt_idx)
    );

    // Pipeline and pointer registers. All stages advance together or not at
    // all; payloads only load alongside a valid bit so idle slots stay quiet
    // and the output payload remains stable once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= IDW'(NREQ - 1);
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_dif    <= '0;
            s1_d      <= '0;
            s1_id     <= '0;
            s2        <= '0;
            out_valid <= 1'b0;
            out_f     <= '0;
            out_id    <= '0;
        end else if (!stall) begin
            if (ptr_load) begin
                ptr <= gnt_idx;
            end
            s1_valid <= grant_any;
            if (grant_any) begin
                s1_sum <= sel_a + sel_b;
                s1_dif <= sel_c - sel_d;
                s1_d   <= sel_d;
                s1_id  <= gnt_idx;
            end
            s2.valid <= s1_valid;
            if (s1_valid) begin
                s2.sum <= s1_sum + s1_dif;
                s2.d   <= s1_d;
                s2.id  <= s1_id;
            end
            out_valid <= s2.valid;
            if (s2.valid) begin
                out_f  <= s2.sum * s2.d;
                out_id <= s2.id;
            end
        end
    end

endmodule

// File: tb/tb_pipe_arb_sched.sv
// tb_pipe_arb_sched
// Self-checking bench for pipe_arb_sched: directed scenarios plus randomized
// traffic compared against a behavioural model (grant rule, F formula and a
// fixed 3-cycle delay line that freezes while the output is held).
// Honours PIPE_ARB_PRIO0_EN in the model and adds a priority scenario.
module tb_pipe_arb_sched;

    localparam int N    = 9;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] op_a, op_b, op_c, op_d;
    logic [NREQ-1:0]   gnt;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_f;
    logic [IDW-1:0]    out_id;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: slot 2 is what the output port should show.
    int            m_ptr;
    bit            m_v [3];
    logic [N-1:0]  m_f [3];
    logic [IDW-1:0] m_id [3];
    int            m_gidx;
    logic [NREQ-1:0] m_gnt;
    bit            m_stall;

    pipe_arb_sched #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .op_d      (op_d),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] ref_f(int i);
        int a, b, c, d, v;
        a = int'(op_a[i*N +: N]);
        b = int'(op_b[i*N +: N]);
        c = int'(op_c[i*N +: N]);
        d = int'(op_d[i*N +: N]);
        v = (a + b + c - d) % 512;
        if (v < 0) v += 512;
        return N'((v * d) % 512);
    endfunction

    task automatic model_reset();
        m_ptr = NREQ - 1;
        for (int s = 0; s < 3; s++) begin
            m_v[s]  = 1'b0;
            m_f[s]  = '0;
            m_id[s] = '0;
        end
    endtask

    task automatic model_eval();
        int c;
        m_stall = m_v[2] && !out_ready;
        m_gidx  = -1;
        m_gnt   = '0;
        if (rst_n && !m_stall) begin
`ifdef PIPE_ARB_PRIO0_EN
            if (req[0]) m_gidx = 0;
`endif
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
`ifdef PIPE_ARB_PRIO0_EN
                if (m_gidx < 0 && c != 0 && req[c]) m_gidx = c;
`else
                if (m_gidx < 0 && req[c]) m_gidx = c;
`endif
            end
            if (m_gidx >= 0) m_gnt[m_gidx] = 1'b1;
        end
    endtask

    task automatic model_clock();
        if (!m_stall) begin
            m_v[2] = m_v[1]; m_f[2] = m_f[1]; m_id[2] = m_id[1];
            m_v[1] = m_v[0]; m_f[1] = m_f[0]; m_id[1] = m_id[0];
            m_v[0] = (m_gidx >= 0);
            if (m_gidx >= 0) begin
                m_f[0]  = ref_f(m_gidx);
                m_id[0] = IDW'(m_gidx);
`ifdef PIPE_ARB_PRIO0_EN
                if (m_gidx != 0) m_ptr = m_gidx;
`else
                m_ptr = m_gidx;
`endif
            end
        end
    endtask

    task automatic rand_ops();
        op_a = 36'({$urandom(), $urandom()});
        op_b = 36'({$urandom(), $urandom()});
        op_c = 36'({$urandom(), $urandom()});
        op_d = 36'({$urandom(), $urandom()});
    endtask

    task automatic set_ops(int i, int a, int b, int c, int d);
        op_a[i*N +: N] = N'(a);
        op_b[i*N +: N] = N'(b);
        op_c[i*N +: N] = N'(c);
        op_d[i*N +: N] = N'(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req = 4'b1111;
        out_ready = 1'b1;
        rand_ops();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt got=%b want=0000", gnt); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid_busy got=%b/%b want=0/0", out_valid, busy);
        end
        checks++;
        if (out_f !== 9'd0 || out_id !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_data got f=%0d id=%0d want 0/0", out_f, out_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req = 4'b0000;
    endtask

    task automatic test_basic();
        int vec [3][5] = '{'{3, 4, 10, 2, 30}, '{300, 300, 0, 1, 87}, '{0, 100, 10, 10, 488}};
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            rand_ops();
            set_ops(0, vec[v][0], vec[v][1], vec[v][2], vec[v][3]);
            req = 4'b0001;
            #1;
            model_eval();
            checks++;
            if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL basic_gnt v=%0d got=%b want=0001", v, gnt); end
            model_clock();
            @(negedge clk);
            req = 4'b0000;
            rand_ops();
            for (int k = 1; k <= 3; k++) begin
                #1;
                model_eval();
                checks++;
                if (k < 3 && out_valid !== 1'b0) begin
                    errors++; $display("[TB] FAIL basic_early v=%0d k=%0d got=%b want=0", v, k, out_valid);
                end else if (k == 3 && (out_valid !== 1'b1 || out_f !== N'(vec[v][4]) || out_id !== 2'd0)) begin
                    errors++;
                    $display("[TB] FAIL basic_result v=%0d got v=%b f=%0d id=%0d want 1/%0d/0",
                             v, out_valid, out_f, out_id, vec[v][4]);
                end
                model_clock();
                @(negedge clk);
            end
        end
    endtask

    task automatic test_rotation();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            req = (k < 8) ? 4'b1111 : 4'b0000;
            rand_ops();
            #1;
            model_eval();
            if (k < 8) begin
                checks++;
                if (gnt !== 4'(1 << (k % 4))) begin
                    errors++; $display("[TB] FAIL rotation_gnt k=%0d got=%b want=%b", k, gnt, 4'(1 << (k % 4)));
                end
            end
            if (k >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== IDW'((k - 3) % 4) || out_f !== m_f[2]) begin
                    errors++;
                    $display("[TB] FAIL rotation_out k=%0d got v=%b id=%0d f=%0d want 1/%0d/%0d",
                             k, out_valid, out_id, out_f, (k - 3) % 4, m_f[2]);
                end
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int drained = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            req       = (k < 8) ? 4'b1111 : 4'b0000;
            out_ready = (k < 3 || k >= 8);
            rand_ops();
            #1;
            model_eval();
            checks++;
            if (gnt !== m_gnt) begin errors++; $display("[TB] FAIL bp_gnt k=%0d got=%b want=%b", k, gnt, m_gnt); end
            if (k >= 3 && k < 8) begin
                checks++;
                if (gnt !== 4'b0000 || out_valid !== 1'b1 || out_id !== 2'd0 || out_f !== m_f[2]) begin
                    errors++;
                    $display("[TB] FAIL bp_hold k=%0d got g=%b v=%b id=%0d f=%0d want 0000/1/0/%0d",
                             k, gnt, out_valid, out_id, out_f, m_f[2]);
                end
            end
            if (k >= 8) begin
                checks++;
                if (out_valid !== m_v[2] || (m_v[2] && (out_f !== m_f[2] || out_id !== m_id[2]))) begin
                    errors++;
                    $display("[TB] FAIL bp_drain k=%0d got v=%b f=%0d id=%0d want %b/%0d/%0d",
                             k, out_valid, out_f, out_id, m_v[2], m_f[2], m_id[2]);
                end
                if (out_valid === 1'b1) begin
                    checks++;
                    if (out_id !== IDW'(drained)) begin
                        errors++; $display("[TB] FAIL bp_order got=%0d want=%0d", out_id, drained);
                    end
                    drained++;
                end
            end
            model_clock();
            @(negedge clk);
        end
        checks++;
        if (drained != 3) begin errors++; $display("[TB] FAIL bp_count got=%0d want=3", drained); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req       = 4'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            #1;
            model_eval();
            checks++;
            if (gnt !== m_gnt) begin errors++; $display("[TB] FAIL rand_gnt k=%0d got=%b want=%b", k, gnt, m_gnt); end
            checks++;
            if (out_valid !== m_v[2] || busy !== (m_v[0] | m_v[1] | m_v[2])) begin
                errors++;
                $display("[TB] FAIL rand_valid k=%0d got v=%b busy=%b want %b/%b",
                         k, out_valid, busy, m_v[2], m_v[0] | m_v[1] | m_v[2]);
            end
            if (m_v[2]) begin
                checks++;
                if (out_f !== m_f[2] || out_id !== m_id[2]) begin
                    errors++;
                    $display("[TB] FAIL rand_data k=%0d got f=%0d id=%0d want %0d/%0d",
                             k, out_f, out_id, m_f[2], m_id[2]);
                end
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            rand_ops();
            #1;
            model_eval();
            model_clock();
            @(negedge clk);
        end
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before got=%b want=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_reset got v=%b busy=%b g=%b want 0/0/0000", out_valid, busy, gnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req = (k == 0) ? 4'b1111 : 4'b0000;
            rand_ops();
            #1;
            model_eval();
            if (k == 0) begin
                checks++;
                if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL mid_first_gnt got=%b want=0001", gnt); end
            end
            checks++;
            if (out_valid !== m_v[2]) begin
                errors++; $display("[TB] FAIL mid_stale k=%0d got=%b want=%b", k, out_valid, m_v[2]);
            end
            model_clock();
            @(negedge clk);
        end
    endtask

`ifdef PIPE_ARB_PRIO0_EN
    task automatic test_prio0();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req = (k < 4) ? 4'b0111 : 4'b0110;
            rand_ops();
            #1;
            model_eval();
            checks++;
            if (k < 4 && gnt !== 4'b0001) begin
                errors++; $display("[TB] FAIL prio_gnt0 k=%0d got=%b want=0001", k, gnt);
            end else if (k >= 4 && gnt !== ((k % 2 == 0) ? 4'b0010 : 4'b0100)) begin
                errors++;
                $display("[TB] FAIL prio_alt k=%0d got=%b want=%b", k, gnt, (k % 2 == 0) ? 4'b0010 : 4'b0100);
            end
            model_clock();
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        req = '0;
        out_ready = 1'b1;
        op_a = '0; op_b = '0; op_c = '0; op_d = '0;
        model_reset();
        test_reset();
        test_basic();
        test_rotation();
        test_backpressure();
        test_reset_midflight();
        test_random();
`ifdef PIPE_ARB_PRIO0_EN
        test_prio0();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
